// File: rtl/l2_clreq_responder_pkg.sv
// ============================================================================
// Package : l2_clreq_pkg
// Brief   : Shared stream-state encoding and copy-command layout for the
//           L1 cache-line request responder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_clreq_pkg;

    localparam int c_nstrms     = 64;
    localparam int c_ncl        = 16;
    localparam int c_l2_ncl     = 256;
    localparam int c_sid_w      = $clog2(c_nstrms);
    localparam int c_clid_w     = $clog2(c_ncl);
    localparam int c_l2_clid_w  = $clog2(c_l2_ncl);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUED = 2'd1,
        S_DONE   = 2'd2
    } strm_state_t;

    typedef struct packed {
        logic [c_sid_w-1:0]     sid;
        logic [c_l2_clid_w-1:0] l2_clid;
        logic [c_clid_w-1:0]    l1_clid;
    } cp_cmd_t;

endpackage

`default_nettype wire

// File: rtl/l2_clreq_responder_rr_arb.sv
// ============================================================================
// Module  : base_rr_arb
// Brief   : N-way round-robin arbiter with one-hot grant; the search starts
//           one past the most recently granted requester.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module base_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic             o_gnt_v,
    output logic [IDX_W-1:0] o_gnt_idx
);

    logic [IDX_W-1:0] r_base;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_k;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_base} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N))
                w_sum = w_sum - (IDX_W+1)'(N);
            w_k = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_k]) begin
                w_found = 1'b1;
                w_idx   = w_k;
            end
        end
    end

    assign o_gnt_v   = w_found;
    assign o_gnt_idx = w_idx;
    assign o_gnt     = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_base <= '0;
        else if (w_found)
            r_base <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/l2_clreq_responder.sv
// ============================================================================
// Module  : l2_clreq_responder
// Brief   : Arbitrates per-stream L1 line requests, issues L2->L1 copy
//           commands and returns per-stream responses on copy completion.
//           Optional checking enabled by macro L2_RSP_CHECK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_clreq_responder
    import l2_clreq_pkg::*;
#(
    parameter int NSTRMS        = c_nstrms,
    parameter int NCL           = c_ncl,
    parameter int L2_NCL        = c_l2_ncl,
    parameter int SID_WIDTH     = $clog2(NSTRMS),
    parameter int CLID_WIDTH    = $clog2(NCL),
    parameter int L2_CLID_WIDTH = $clog2(L2_NCL)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSTRMS-1:0]        i_rst_v,
    output logic [NSTRMS-1:0]        i_rst_r,
    input  logic [NSTRMS-1:0]        i_req_v,
    output logic [NSTRMS-1:0]        i_req_r,
    output logic                     o_cp_v,
    input  logic                     o_cp_r,
    output logic [SID_WIDTH-1:0]     o_cp_sid,
    output logic [L2_CLID_WIDTH-1:0] o_cp_l2_clid,
    output logic [CLID_WIDTH-1:0]    o_cp_l1_clid,
    input  logic                     i_done_v,
    input  logic [SID_WIDTH-1:0]     i_done_sid,
    output logic [NSTRMS-1:0]        o_rsp_v,
    input  logic [NSTRMS-1:0]        o_rsp_r,
    output logic                     o_err
);

    strm_state_t [NSTRMS-1:0]                     w_state;
    logic        [NSTRMS-1:0][L2_CLID_WIDTH-1:0]  w_l2_ptr;
    logic        [NSTRMS-1:0][CLID_WIDTH-1:0]     w_l1_ptr;
    logic        [NSTRMS-1:0]                     w_cand;
    logic        [NSTRMS-1:0]                     w_gnt;
    logic                                         w_gnt_v;
    logic        [SID_WIDTH-1:0]                  w_gnt_idx;
    logic                                         w_can_load;
    logic                                         r_cp_v;
    cp_cmd_t                                      r_cmd;

    // A new command may load when the slot is empty or emptying this cycle.
    assign w_can_load = ~r_cp_v | o_cp_r;

    base_rr_arb #(
        .N     (NSTRMS),
        .IDX_W (SID_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_cand & {NSTRMS{w_can_load}}),
        .o_gnt     (w_gnt),
        .o_gnt_v   (w_gnt_v),
        .o_gnt_idx (w_gnt_idx)
    );

    assign i_req_r = w_gnt;

    generate
        for (genvar j = 0; j < NSTRMS; j++) begin : g_strm
            strm_state_t              r_state;
            logic [L2_CLID_WIDTH-1:0] r_l2_ptr;
            logic [CLID_WIDTH-1:0]    r_l1_ptr;
            logic                     w_done_hit;

            assign w_done_hit  = i_done_v & (i_done_sid == SID_WIDTH'(j));
            // Reset wins over a same-cycle request.
            assign w_cand[j]   = i_req_v[j] & ~i_rst_v[j] & (r_state == S_IDLE);
            assign i_rst_r[j]  = (r_state == S_IDLE);
            assign o_rsp_v[j]  = (r_state == S_DONE);
            assign w_state[j]  = r_state;
            assign w_l2_ptr[j] = r_l2_ptr;
            assign w_l1_ptr[j] = r_l1_ptr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state  <= S_IDLE;
                    r_l2_ptr <= '0;
                    r_l1_ptr <= '0;
                end else begin
                    if (i_rst_v[j] && (r_state == S_IDLE)) begin
                        r_l2_ptr <= '0;
                        r_l1_ptr <= '0;
                    end else if (w_gnt[j]) begin
                        r_l2_ptr <= (r_l2_ptr == L2_CLID_WIDTH'(L2_NCL-1)) ? '0 : r_l2_ptr + 1'b1;
                        r_l1_ptr <= (r_l1_ptr == CLID_WIDTH'(NCL-1)) ? '0 : r_l1_ptr + 1'b1;
                    end
                    case (r_state)
                        S_IDLE:   if (w_gnt[j])      r_state <= S_ISSUED;
                        S_ISSUED: if (w_done_hit)    r_state <= S_DONE;
                        S_DONE:   if (o_rsp_r[j])    r_state <= S_IDLE;
                        default:                     r_state <= S_IDLE;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cp_v <= 1'b0;
            r_cmd  <= '0;
        end else if (w_can_load) begin
            r_cp_v <= w_gnt_v;
            if (w_gnt_v) begin
                r_cmd.sid     <= w_gnt_idx;
                r_cmd.l2_clid <= w_l2_ptr[w_gnt_idx];
                r_cmd.l1_clid <= w_l1_ptr[w_gnt_idx];
            end
        end
    end

    assign o_cp_v       = r_cp_v;
    assign o_cp_sid     = r_cmd.sid;
    assign o_cp_l2_clid = r_cmd.l2_clid;
    assign o_cp_l1_clid = r_cmd.l1_clid;

`ifdef L2_RSP_CHECK_EN
    logic w_stray;
    logic r_err;

    assign w_stray = i_done_v & (w_state[i_done_sid] != S_ISSUED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_stray)
            r_err <= 1'b1;
    end

    assign o_err = r_err;

    a_no_stray_done: assert property (@(posedge clk) disable iff (!rst_n) !w_stray)
        else $warning("done strobe for stream %0d not in ISSUED", i_done_sid);

    a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_cp_v && !o_cp_r) |=> (r_cp_v && $stable(r_cmd)))
        else $error("copy command changed while stalled");
`else
    assign o_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_clreq_responder.sv
// ============================================================================
// Module  : tb_l2_clreq_responder
// Brief   : Directed self-checking bench for l2_clreq_responder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_clreq_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rst_v, rst_r, req_v, req_r, rsp_v, rsp_r;
    logic        cp_v, cp_r;
    logic [5:0]  cp_sid;
    logic [7:0]  cp_l2;
    logic [3:0]  cp_l1;
    logic        done_v;
    logic [5:0]  done_sid;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    l2_clreq_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rst_v      (rst_v),
        .i_rst_r      (rst_r),
        .i_req_v      (req_v),
        .i_req_r      (req_r),
        .o_cp_v       (cp_v),
        .o_cp_r       (cp_r),
        .o_cp_sid     (cp_sid),
        .o_cp_l2_clid (cp_l2),
        .o_cp_l1_clid (cp_l1),
        .i_done_v     (done_v),
        .i_done_sid   (done_sid),
        .o_rsp_v      (rsp_v),
        .o_rsp_r      (rsp_r),
        .o_err        (err)
    );

    function automatic int oh_idx(input logic [63:0] v);
        oh_idx = -1;
        for (int i = 0; i < 64; i++)
            if (v[i]) oh_idx = i;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rst_v    = '0;
        req_v    = '0;
        rsp_r    = '1;
        cp_r     = 1'b1;
        done_v   = 1'b0;
        done_sid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rst_v    = '0;
        req_v    = '0;
        rsp_r    = '1;
        cp_r     = 1'b1;
        done_v   = 1'b0;
        done_sid = '0;
        #1;
        tests++;
        if ({cp_v, rsp_v, err, req_r} !== {1'b0, 64'd0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL reset_outputs: cp_v=%b rsp_v=%h err=%b req_r=%h, want all 0",
                     cp_v, rsp_v, err, req_r);
        end
        tests++;
        if (rst_r !== '1) begin
            fails++;
            $display("FAIL reset_idle: rst_r=%h, want all ones", rst_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_v[5] = 1'b1;
        #1;
        tests++;
        if (req_r !== (64'd1 << 5)) begin
            fails++;
            $display("FAIL single_grant: req_r=%h, want %h", req_r, 64'd1 << 5);
        end
        @(negedge clk);
        req_v = '0;
        tests++;
        if ({cp_v, cp_sid, cp_l2, cp_l1} !== {1'b1, 6'd5, 8'd0, 4'd0}) begin
            fails++;
            $display("FAIL single_cmd: v=%b sid=%0d l2=%0d l1=%0d, want 1/5/0/0",
                     cp_v, cp_sid, cp_l2, cp_l1);
        end
        done_v   = 1'b1;
        done_sid = 6'd5;
        @(negedge clk);
        done_v = 1'b0;
        tests++;
        if (rsp_v !== (64'd1 << 5)) begin
            fails++;
            $display("FAIL single_rsp: rsp_v=%h, want %h", rsp_v, 64'd1 << 5);
        end
        @(negedge clk);
        tests++;
        if (rsp_v !== 64'd0 || rst_r[5] !== 1'b1) begin
            fails++;
            $display("FAIL single_idle: rsp_v=%h rst_r5=%b, want 0/1", rsp_v, rst_r[5]);
        end
    endtask

    task automatic test_fairness();
        int exp_seq[6] = '{1, 2, 3, 1, 2, 3};
        int got;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_v[3:1] = 3'b111;
            done_v     = cp_v;
            done_sid   = cp_sid;
            #1;
            got = oh_idx(req_r);
            tests++;
            if (got !== exp_seq[c]) begin
                fails++;
                $display("FAIL fair_grant_%0d: granted=%0d, want %0d", c, got, exp_seq[c]);
            end
        end
        @(negedge clk);
        req_v  = '0;
        done_v = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int r = 0; r < 17; r++) begin
            @(negedge clk);
            req_v[0] = 1'b1;
            @(negedge clk);
            req_v[0] = 1'b0;
            tests++;
            if ({cp_v, cp_sid, cp_l1, cp_l2} !== {1'b1, 6'd0, 4'(r % 16), 8'(r)}) begin
                fails++;
                $display("FAIL wrap_round_%0d: v=%b sid=%0d l1=%0d l2=%0d, want 1/0/%0d/%0d",
                         r, cp_v, cp_sid, cp_l1, cp_l2, r % 16, r);
            end
            done_v   = 1'b1;
            done_sid = 6'd0;
            @(negedge clk);
            done_v = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        cp_r       = 1'b0;
        req_v[3:1] = 3'b111;
        #1;
        tests++;
        if (req_r !== 64'h2) begin
            fails++;
            $display("FAIL bp_first_grant: req_r=%h, want 2", req_r);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (req_r !== 64'd0 || {cp_v, cp_sid, cp_l2, cp_l1} !== {1'b1, 6'd1, 8'd0, 4'd0}) begin
                fails++;
                $display("FAIL bp_stall_%0d: req_r=%h v=%b sid=%0d l2=%0d l1=%0d, want 0/1/1/0/0",
                         k, req_r, cp_v, cp_sid, cp_l2, cp_l1);
            end
        end
        @(negedge clk);
        cp_r = 1'b1;
        #1;
        tests++;
        if (req_r !== 64'h4 || cp_sid !== 6'd1) begin
            fails++;
            $display("FAIL bp_release: req_r=%h sid=%0d, want 4/1", req_r, cp_sid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (req_r !== 64'h8 || cp_v !== 1'b1 || cp_sid !== 6'd2) begin
            fails++;
            $display("FAIL bp_next: req_r=%h v=%b sid=%0d, want 8/1/2", req_r, cp_v, cp_sid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (req_r !== 64'd0 || cp_v !== 1'b1 || cp_sid !== 6'd3) begin
            fails++;
            $display("FAIL bp_last: req_r=%h v=%b sid=%0d, want 0/1/3", req_r, cp_v, cp_sid);
        end
        req_v = '0;
    endtask

    task automatic test_reset_race();
        apply_reset();
        @(negedge clk);
        req_v[7] = 1'b1;
        @(negedge clk);
        req_v[7] = 1'b0;
        done_v   = 1'b1;
        done_sid = 6'd7;
        @(negedge clk);
        done_v = 1'b0;
        @(negedge clk);
        req_v[7] = 1'b1;
        rst_v[7] = 1'b1;
        #1;
        tests++;
        if (rst_r[7] !== 1'b1 || req_r !== 64'd0) begin
            fails++;
            $display("FAIL race_same_cycle: rst_r7=%b req_r=%h, want 1/0", rst_r[7], req_r);
        end
        @(negedge clk);
        rst_v[7] = 1'b0;
        #1;
        tests++;
        if (req_r !== (64'd1 << 7)) begin
            fails++;
            $display("FAIL race_regrant: req_r=%h, want %h", req_r, 64'd1 << 7);
        end
        @(negedge clk);
        req_v[7] = 1'b0;
        tests++;
        if ({cp_v, cp_sid, cp_l2, cp_l1} !== {1'b1, 6'd7, 8'd0, 4'd0}) begin
            fails++;
            $display("FAIL race_cleared_ptr: v=%b sid=%0d l2=%0d l1=%0d, want 1/7/0/0",
                     cp_v, cp_sid, cp_l2, cp_l1);
        end
    endtask

    task automatic test_stray_done();
        logic exp_err;
`ifdef L2_RSP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        apply_reset();
        @(negedge clk);
        done_v   = 1'b1;
        done_sid = 6'd9;
        @(negedge clk);
        done_v = 1'b0;
        tests++;
        if (rsp_v !== 64'd0 || err !== exp_err) begin
            fails++;
            $display("FAIL stray_done: rsp_v=%h err=%b, want 0/%b", rsp_v, err, exp_err);
        end
        req_v[9] = 1'b1;
        @(negedge clk);
        req_v[9] = 1'b0;
        tests++;
        if (cp_v !== 1'b1 || cp_sid !== 6'd9) begin
            fails++;
            $display("FAIL stray_issue: v=%b sid=%0d, want 1/9", cp_v, cp_sid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (cp_v !== 1'b0 || rsp_v !== 64'd0 || rst_r !== '1 || err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: v=%b rsp_v=%h rst_r=%h err=%b, want 0/0/all1/0",
                     cp_v, rsp_v, rst_r, err);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        req_v[9] = 1'b1;
        #1;
        tests++;
        if (req_r !== (64'd1 << 9)) begin
            fails++;
            $display("FAIL async_regrant: req_r=%h, want %h", req_r, 64'd1 << 9);
        end
        @(negedge clk);
        req_v[9] = 1'b0;
        tests++;
        if (cp_l2 !== 8'd0 || cp_l1 !== 4'd0) begin
            fails++;
            $display("FAIL async_ptr_clear: l2=%0d l1=%0d, want 0/0", cp_l2, cp_l1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_reset_race();
        test_stray_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
